// File: rtl/lshifup_hs_pkg.sv
// Shared types and limits for the lshifup handshake receiver/transmitter pair.
package lshifup_hs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        ACK  = 2'b10
    } hs_state_t;

    localparam int NSYNC_MIN = 2;
    localparam int NSYNC_MAX = 4;
    localparam int W_MAX     = 32;

endpackage

// File: rtl/lshifup_sync.sv
// Single-bit NSYNC-flop synchronizer, cleared to 0 by async reset.
// Latency NSYNC edges; no backpressure.
module lshifup_sync #(
    parameter int NSYNC = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);

    logic [NSYNC-1:0] r_ff;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ff <= '0;
        end else begin
            r_ff <= {r_ff[NSYNC-2:0], i_d};
        end
    end

    assign o_q = r_ff[NSYNC-1];

endmodule

// File: rtl/lshifup_hs_rx.sv
// 4-phase REQ/ACK receiver into the 3.3 V domain; REQ rise to Y_VALID in NSYNC+1 edges.
// Word held while Y_READY is low; ACK withheld until accept. Parity option: LSHIFUP_HS_RX_PARITY_EN.
module lshifup_hs_rx
    import lshifup_hs_pkg::*;
#(
    parameter int W     = 8,
    parameter int NSYNC = 2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         A_REQ,
    input  logic [W-1:0] A_DATA,
`ifdef LSHIFUP_HS_RX_PARITY_EN
    input  logic         A_PAR,
    output logic         Y_PERR,
`endif
    output logic         Y_ACK,
    output logic         Y_VALID,
    output logic [W-1:0] Y_DATA,
    input  logic         Y_READY
);

    if (W < 1 || W > W_MAX || NSYNC < NSYNC_MIN || NSYNC > NSYNC_MAX) begin : g_bad_params
        $error("lshifup_hs_rx: W or NSYNC out of range");
    end

    logic         w_req_s;
    hs_state_t    r_state;
    logic         r_ack;
    logic         r_valid;
    logic [W-1:0] r_data;
`ifdef LSHIFUP_HS_RX_PARITY_EN
    logic         r_perr;
`endif

    lshifup_sync #(
        .NSYNC (NSYNC)
    ) u_req_sync (
        .i_clk (CLK),
        .i_rst (RST),
        .i_d   (A_REQ),
        .o_q   (w_req_s)
    );

    // IDLE acts on the req_s level, so a REQ still high after reset re-delivers the word.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
            r_ack   <= 1'b0;
            r_valid <= 1'b0;
            r_data  <= '0;
`ifdef LSHIFUP_HS_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_s) begin
                        r_data  <= A_DATA;
                        r_valid <= 1'b1;
`ifdef LSHIFUP_HS_RX_PARITY_EN
                        r_perr  <= (^A_DATA) ^ A_PAR;
`endif
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (Y_READY) begin
                        r_valid <= 1'b0;
                        r_ack   <= 1'b1;
`ifdef LSHIFUP_HS_RX_PARITY_EN
                        r_perr  <= 1'b0;
`endif
                        r_state <= ACK;
                    end
                end
                ACK: begin
                    // An early REQ drop lands here with req_s already low: ACK lasts one cycle.
                    if (!w_req_s) begin
                        r_ack   <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_ack   <= 1'b0;
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign Y_ACK   = r_ack;
    assign Y_VALID = r_valid;
    assign Y_DATA  = r_data;
`ifdef LSHIFUP_HS_RX_PARITY_EN
    assign Y_PERR  = r_perr;
`endif

endmodule
